// File: rtl/keypad_scan_sequencer.sv
// keypad_scan_sequencer: scans a column-driven keypad, debounces whole scans and
// reports each accepted press as a single event through a valid/ready handshake.
module keypad_scan_sequencer #(
    parameter int ColumnHeight  = 4,
    parameter int RowWidth      = 4,
    parameter int SettleCycles  = 3,
    parameter int DebounceScans = 2,
    parameter int CodeWidth     = $clog2(ColumnHeight * RowWidth)
) (
    input  logic                    Clock,
    input  logic                    Reset,
    output logic [ColumnHeight-1:0] ColumnPins,
    input  logic [RowWidth-1:0]     RowPins,
    output logic                    KeyValid,
    output logic [CodeWidth-1:0]    KeyCode,
    input  logic                    KeyReady,
    output logic                    KeyDown,
    output logic                    KeyDropped
);
    localparam int ColW   = ColumnHeight > 1 ? $clog2(ColumnHeight) : 1;
    localparam int SetW   = SettleCycles > 0 ? $clog2(SettleCycles + 1) : 1;
    localparam int StabW  = $clog2(DebounceScans + 1);
    localparam logic [1:0] DRIVE  = 2'd0;
    localparam logic [1:0] SAMPLE = 2'd1;
    localparam logic [1:0] EVAL   = 2'd2;

    logic [1:0]           state;
    logic [ColW-1:0]      col;
    logic [SetW-1:0]      settle;
    logic [StabW-1:0]     stab;
    logic [StabW-1:0]     stab_next;
    logic [RowWidth-1:0]  row_meta;
    logic [RowWidth-1:0]  row_sync;
    logic                 hit_valid;
    logic [CodeWidth-1:0] hit;
    logic [CodeWidth-1:0] hit_code;
    logic                 prev_valid;
    logic [CodeWidth-1:0] prev_code;
    logic                 same;
    int                   low_idx;

    // Reset forces the column lines idle immediately, not only after the edge.
    always_comb begin
        ColumnPins = (Reset || state == EVAL) ? '1 : ~(ColumnHeight'(1) << col);
    end

    always_comb begin
        low_idx = 0;
        for (int i = RowWidth - 1; i >= 0; i--)
            if (!row_sync[i]) low_idx = i;
        hit_code = CodeWidth'(int'(col) * RowWidth + low_idx);
    end

    // "No key" results compare equal regardless of the stale code bits.
    always_comb begin
        same      = (hit_valid == prev_valid) && (!hit_valid || hit == prev_code);
        stab_next = !same ? StabW'(1) :
                    (stab == StabW'(DebounceScans)) ? stab : stab + StabW'(1);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            row_meta   <= '1;
            row_sync   <= '1;
            state      <= DRIVE;
            col        <= '0;
            settle     <= '0;
            hit_valid  <= 1'b0;
            hit        <= '0;
            prev_valid <= 1'b0;
            prev_code  <= '0;
            stab       <= '0;
            KeyValid   <= 1'b0;
            KeyCode    <= '0;
            KeyDown    <= 1'b0;
            KeyDropped <= 1'b0;
        end else begin
            row_meta   <= RowPins;
            row_sync   <= row_meta;
            KeyDropped <= 1'b0;
            if (KeyValid && KeyReady) KeyValid <= 1'b0;
            if (state == DRIVE) begin
                if (settle == SetW'(SettleCycles)) begin
                    settle <= '0;
                    state  <= SAMPLE;
                end else begin
                    settle <= settle + SetW'(1);
                end
            end else if (state == SAMPLE) begin
                if (!(&row_sync) && !hit_valid) begin
                    hit_valid <= 1'b1;
                    hit       <= hit_code;
                end
                if (col == ColW'(ColumnHeight - 1)) begin
                    state <= EVAL;
                end else begin
                    col   <= col + ColW'(1);
                    state <= DRIVE;
                end
            end else begin
                col        <= '0;
                state      <= DRIVE;
                hit_valid  <= 1'b0;
                hit        <= '0;
                prev_valid <= hit_valid;
                prev_code  <= hit;
                stab       <= stab_next;
                if (stab_next == StabW'(DebounceScans)) begin
                    if (hit_valid && !KeyDown) begin
                        KeyDown <= 1'b1;
                        // A new event may replace one being accepted this very cycle.
                        if (!KeyValid || KeyReady) begin
                            KeyValid <= 1'b1;
                            KeyCode  <= hit;
                        end else begin
                            KeyDropped <= 1'b1;
                        end
                    end else if (!hit_valid && KeyDown) begin
                        KeyDown <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_keypad_scan_sequencer.sv
// tb_keypad_scan_sequencer: randomized keypad bench with a scan-level reference
// model feeding an event scoreboard checked by an independent monitor.
module tb_keypad_scan_sequencer;
    localparam int P = 21;
    localparam int D = 2;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       KeyReady = 1'b0;
    logic [3:0] ColumnPins;
    logic [3:0] RowPins;
    logic       KeyValid;
    logic [3:0] KeyCode;
    logic       KeyDown;
    logic       KeyDropped;

    logic [15:0] mask = '0;
    int vectors = 0;
    int miscompares = 0;
    int cnt = 0;
    int ready_mode = 1;
    bit mv = 0;
    bit down = 0;
    bit drop_exp = 0;
    int q[$];
    int hist[$];

    always #5 Clock = ~Clock;

    keypad_scan_sequencer dut (
        .Clock(Clock), .Reset(Reset), .ColumnPins(ColumnPins), .RowPins(RowPins),
        .KeyValid(KeyValid), .KeyCode(KeyCode), .KeyReady(KeyReady),
        .KeyDown(KeyDown), .KeyDropped(KeyDropped)
    );

    // Key k sits at column k/4, row k%4 and pulls its row low while its column is driven.
    always_comb begin
        RowPins = '1;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (!ColumnPins[c] && mask[c*4+r]) RowPins[r] = 1'b0;
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [15:0] m);
        for (int i = 0; i < 16; i++) if (m[i]) return i;
        return -1;
    endfunction

    // Advance one clock and update the model; a scan ends on every P-th edge after reset.
    task automatic step();
        bit acc, ev, stable, mv_n;
        int res;
        @(posedge Clock);
        #2;
        drop_exp = 0;
        if (Reset) begin
            mv = 0;
            down = 0;
            q.delete();
            hist.delete();
            cnt = 0;
        end else begin
            cnt++;
            acc = mv && KeyReady;
            ev = 0;
            res = -1;
            if (cnt % P == 0) begin
                res = lowest(mask);
                hist.push_back(res);
                while (hist.size() > D) void'(hist.pop_front());
                stable = (hist.size() == D);
                foreach (hist[i]) if (hist[i] != res) stable = 0;
                if (stable && res >= 0 && !down) begin
                    down = 1;
                    ev = 1;
                end else if (stable && res < 0 && down) begin
                    down = 0;
                end
            end
            mv_n = acc ? 1'b0 : mv;
            if (ev) begin
                if (!mv || KeyReady) begin
                    q.push_back(res);
                    mv_n = 1;
                end else begin
                    drop_exp = 1;
                end
            end
            mv = mv_n;
        end
        KeyReady = ready_mode == 2 ? ($urandom_range(0, 3) != 0) : ready_mode[0];
    endtask

    task automatic run_scans(input logic [15:0] m, input int n, input int mode);
        int e = 0;
        mask = m;
        ready_mode = mode;
        KeyReady = mode == 2 ? ($urandom_range(0, 3) != 0) : mode[0];
        while (e < n) begin
            step();
            if (!Reset && cnt % P == 0) e++;
        end
    endtask

    initial begin
        logic [3:0] one = 4'b0001;
        logic [3:0] exp_col;
        forever begin
            @(negedge Clock);
            exp_col = (Reset || cnt % P == 20) ? 4'hF : ~(one << ((cnt % P) / 5));
            chk("column_pins", ColumnPins, exp_col);
            chk("key_valid", KeyValid, mv);
            chk("key_down", KeyDown, down);
            chk("key_dropped", KeyDropped, drop_exp);
            if (KeyValid && q.size() > 0) chk("key_code", KeyCode, q[0]);
            if (KeyValid && KeyReady) begin
                chk("event_queue", q.size(), 1);
                if (q.size() > 0) void'(q.pop_front());
            end
        end
    end

    initial begin
        logic [15:0] m = '0;
        int r;
        Reset = 1;
        repeat (3) step();
        chk("reset_code", KeyCode, 0);
        chk("reset_cols", ColumnPins, 15);
        Reset = 0;
        run_scans(16'h0000, 20, 1);
        run_scans(16'h0200, 10, 1);
        run_scans(16'h0000, 2, 1);
        run_scans(16'h0200, 3, 1);
        run_scans(16'h0000, 3, 1);
        run_scans(16'h0020, 1, 1);
        run_scans(16'h0000, 3, 1);
        run_scans(16'h0200, 3, 0);
        run_scans(16'h0000, 3, 0);
        run_scans(16'h0001, 3, 0);
        run_scans(16'h0000, 3, 0);
        run_scans(16'h0000, 2, 1);
        run_scans(16'h2048, 3, 1);
        run_scans(16'h0000, 3, 1);
        run_scans(16'h4080, 3, 1);
        run_scans(16'h0000, 3, 1);
        run_scans(16'h0200, 3, 0);
        repeat (4) step();
        Reset = 1;
        step();
        chk("rst_valid", KeyValid, 0);
        chk("rst_down", KeyDown, 0);
        chk("rst_cols", ColumnPins, 15);
        step();
        Reset = 0;
        mask = '0;
        repeat (300) begin
            r = $urandom_range(0, 9);
            if (r < 4) m = '0;
            else if (r < 8) m = 16'(1) << $urandom_range(0, 15);
            else if (r == 8) m = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
            run_scans(m, $urandom_range(1, 4), 2);
        end
        run_scans(16'h0000, 4, 1);
        chk("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/keypad_scan_sequencer.md
KEYPAD_SCAN_SEQUENCER -- requirements
Module: keypad_scan_sequencer

Interface
REQ-001 The module SHALL provide parameter ColumnHeight, default 4, number of driven column lines.
REQ-002 The module SHALL provide parameter RowWidth, default 4, number of sensed row lines.
REQ-003 The module SHALL provide parameter SettleCycles, default 3, extra clocks a column is driven before rows are sampled.
REQ-004 The module SHALL provide parameter DebounceScans, default 2, consecutive identical full scans required to accept a press or release.
REQ-005 The module SHALL provide parameter CodeWidth, default $clog2(ColumnHeight*RowWidth), KeyCode width.
REQ-006 Clock  input  1  sole clock; all state updates on rising edge.
REQ-007 Reset  input  1  reset, synchronous and active-high.
REQ-008 ColumnPins  output  ColumnHeight  active-low one-hot column drive.
REQ-009 RowPins  input  RowWidth  active-low row sense; synchronised internally.
REQ-010 KeyValid  output  1  key-press event pending.
REQ-011 KeyCode  output  CodeWidth  code of pending event.
REQ-012 KeyReady  input  1  consumer accepts event when high with KeyValid.
REQ-013 KeyDown  output  1  debounced "a key is held" status.
REQ-014 KeyDropped  output  1  one-cycle pulse when an event is lost to backpressure.

Function
REQ-015 RowPins SHALL pass through a 2-flop synchroniser; all "row" references below mean the synchronised value.
REQ-016 FSM states SHALL be DRIVE, SAMPLE, EVAL; reset enters DRIVE with column index 0.
REQ-017 DRIVE: ColumnPins = ~(1<<col); settle counter counts SettleCycles clocks, then -> SAMPLE.
REQ-018 SAMPLE (1 cycle, column still driven): if any row bit low and no hit recorded this scan, record hit = col*RowWidth + lowest low row index; then col==ColumnHeight-1 -> EVAL, else col+1 -> DRIVE.
REQ-019 Column index SHALL wrap from ColumnHeight-1 to 0 on EVAL; scan period = ColumnHeight*(SettleCycles+2)+1 clocks.
REQ-020 EVAL (1 cycle, ColumnPins all ones): compare scan result (hit code or "none") with previous scan result; equal -> stability counter +1 (saturating at DebounceScans), else counter = 1; then clear hit, -> DRIVE.
REQ-021 Press accept: stability counter reaches DebounceScans with result = code and KeyDown=0 -> KeyDown=1, raise event with that code.
REQ-022 Release accept: stability counter reaches DebounceScans with result = none and KeyDown=1 -> KeyDown=0; no event.
REQ-023 A held key SHALL generate exactly one event; a changed code while KeyDown=1 SHALL NOT generate an event until release is accepted.
REQ-024 Handshake: KeyValid and KeyCode SHALL hold stable until the cycle KeyValid&&KeyReady, after which KeyValid=0 next cycle.
REQ-025 Event raised while KeyValid=1 and not accepted same cycle SHALL be discarded, KeyCode unchanged, KeyDropped pulsed 1 cycle.
REQ-026 Event raised in the same cycle the pending one is accepted SHALL load KeyCode and keep KeyValid=1.
REQ-027 Multiple simultaneous keys SHALL resolve to the lowest column, then lowest row.

Reset
REQ-028 While Reset=1: ColumnPins = all ones, KeyValid=0, KeyCode=0, KeyDown=0, KeyDropped=0, counters, hit and previous result cleared (previous = none).
REQ-029 Reset asserted mid-scan or with KeyValid=1 SHALL take effect on the next rising edge, discarding any pending event; first cycle after release drives column 0.

Verification (ColumnHeight=4, RowWidth=4, SettleCycles=3, DebounceScans=2)
REQ-030 Reset 3 cycles, RowPins=4'b1111 -> ColumnPins=4'b1111, KeyValid=0, KeyCode=0; 20 scans idle -> no KeyValid.
REQ-031 RowPins=4'b1101 whenever ColumnPins=4'b1011, held -> after 2nd EVAL with hit KeyValid=1, KeyCode=9, KeyDown=1; KeyReady pulse -> KeyValid=0.
REQ-032 Same key present in one scan only (bounce) -> KeyValid stays 0, KeyDown stays 0.
REQ-033 Key 9 held 10 scans, released 2 scans, pressed again -> exactly two events, KeyDown falls between them.
REQ-034 KeyReady=0; press/release key 9 then key 0 -> KeyCode stays 9, KeyDropped pulses once; KeyReady=1 -> KeyValid=0.
REQ-035 Reset asserted during SAMPLE with KeyValid=1 -> next cycle ColumnPins=4'b1111, KeyValid=0, KeyDown=0.
